input_buffer: RTL
=================

Name: input_buffer

Overview:
- Byte FIFO between the UART receiver and the core's I/O input path.
- Buffers incoming serial bytes.
- Serves the pipeline's input request as a zero-extended byte or a little-endian 32-bit word.
- Answers with a one-cycle input_valid pulse, which releases the hazard unit's input stall.

Parameters:
DEPTH, 16, FIFO capacity in bytes; must be a power of two, at least 4.
ADDR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
rx_data  in  8  received byte from UART receiver
rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
input_req  in  1  level request from hazard unit; held high until the cycle input_valid is high
input_word  in  1  sampled with the request: 1 = 4-byte word, 0 = single byte
input_valid  out  1  one-cycle pulse; input_data valid this cycle
input_data  out  32  result; byte mode {24'b0, b0}; word mode {b3,b2,b1,b0}, b0 = first byte popped
count  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
overflow  out  1  sticky; set when a byte arrives while the FIFO is full

Behaviour:
- Reset (rst high at a clk edge):
  - Pointers, count, state and byte counter go to 0.
  - input_valid=0, input_data=0, overflow=0.
  - State = IDLE.
  - Reset mid-transaction discards any partially assembled word; no input_valid is produced.
- FIFO write:
  - rx_valid=1 and count<DEPTH: rx_data written at wr_ptr; wr_ptr increments, wrapping modulo DEPTH.
  - rx_valid=1 and count==DEPTH: byte dropped, overflow set; overflow clears only on rst.
- FIFO read:
  - A pop happens only in COLLECT when count!=0; at most one pop per cycle.
  - rd_ptr wraps modulo DEPTH.
- Simultaneous push and pop in one cycle: both occur and count is unchanged.
  - This holds at count==DEPTH too: the pop frees a slot, so the push is accepted with no overflow.
  - Push into an empty FIFO is not visible to a pop in the same cycle; the byte is poppable next cycle.
- State machine:
  - IDLE:
    - input_valid=0.
    - If input_req=1: latch need = input_word ? 4 : 1, clear byte counter and assembly register, go to COLLECT.
  - COLLECT:
    - If input_req=0: abort. Already-popped bytes are lost; go to IDLE with no pulse.
    - Else if count!=0: pop a byte into lane [8*cnt +: 8] and increment cnt.
    - When the pop makes cnt==need, go to RESP.
    - If count==0, wait indefinitely; the stall persists.
  - RESP:
    - input_valid=1 for exactly this cycle.
    - input_data = assembled value, held unchanged until the next completed transaction.
    - Always returns to IDLE.
    - input_req is ignored in RESP; the hazard unit drops it combinationally this cycle.
- Latency with data available:
  - Byte: input_req first high in cycle 0 → input_valid in cycle 2.
  - Word: input_req first high in cycle 0 → input_valid in cycle 5.
- A new request may start in the cycle after RESP; back-to-back requests are legal.
- count output is registered and reflects the updates of the previous edge.

Test Plan:
- Byte read: push 0x41, then 0x42; hold input_req with input_word=0 → input_valid in cycle 2 with input_data=0x00000041; count goes 2→1.
- Word read: push 0x11,0x22,0x33,0x44; request with input_word=1 → input_valid after 5 cycles, input_data=0x44332211, count=0.
- Starved word: request a word with the FIFO empty, then push one byte every 10 cycles → input_valid exactly 2 cycles after the 4th push, input_data matches, no earlier pulse.
- Full FIFO: push 17 bytes with DEPTH=16 → count=16, overflow=1, 17th byte absent. Then push and pop in the same cycle at full → count stays 16, no additional drop.
- Wrap-around: perform 40 single-byte push/pop pairs, values 0..39 → data returned in order across the pointer wrap; count never exceeds 1.
- Reset mid-word: after 2 bytes of a word request are popped, pulse rst → no input_valid, count=0, overflow=0, input_data=0. A following byte request on fresh data returns correctly.

Source files
------------

// File: rtl/input_buffer.sv
// rtl/input_buffer.sv - byte FIFO between UART receiver and core input path
//
// Buffers received bytes and answers the pipeline's input request with either
// a zero-extended byte or a little-endian 32-bit word.
//
// Ports:
//   clk          core clock
//   rst          synchronous active-high reset
//   rx_data      received byte from the UART receiver
//   rx_valid     one-cycle strobe qualifying rx_data
//   input_req    level request from the hazard unit, held until input_valid
//   input_word   sampled with the request: 1 = 4-byte word, 0 = single byte
//   input_valid  one-cycle pulse, input_data valid this cycle
//   input_data   byte mode {24'b0, b0}; word mode {b3, b2, b1, b0}
//   count        registered FIFO occupancy, 0..DEPTH
//   overflow     sticky; a byte arrived while the FIFO was full
module input_buffer #(
    parameter int  DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              input_req,
    input  logic              input_word,
    output logic              input_valid,
    output logic [31:0]       input_data,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [2:0]        need, cnt;
    logic [31:0]       asm_q, asm_next;
    logic [31:0]       data_q;
    logic              push, pop, last_pop;

    // A pop only looks at the registered count, so a byte pushed into an
    // empty FIFO becomes poppable one cycle later.
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        last_pop = 1'b0;
        case (state)
            IDLE: begin
                if (input_req) state_n = COLLECT;
            end
            COLLECT: begin
                if (!input_req) begin
                    state_n = IDLE;
                end else if (count != '0) begin
                    pop = 1'b1;
                    if (cnt + 3'd1 == need) begin
                        last_pop = 1'b1;
                        state_n  = RESP;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        asm_next = asm_q;
        asm_next[8*cnt[1:0] +: 8] = mem[rd_ptr];
    end

    // A pop in the same cycle frees a slot, so a push at full is accepted.
    assign push = rx_valid && ((count != FULL) || pop);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            need     <= 3'd0;
            cnt      <= 3'd0;
            asm_q    <= 32'd0;
            data_q   <= 32'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (rx_valid && !push) overflow <= 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (state == IDLE && input_req) begin
                need  <= input_word ? 3'd4 : 3'd1;
                cnt   <= 3'd0;
                asm_q <= 32'd0;
            end else if (pop) begin
                cnt   <= cnt + 3'd1;
                asm_q <= asm_next;
            end

            if (last_pop) data_q <= asm_next;
        end
    end

    assign input_valid = (state == RESP);
    assign input_data  = data_q;

endmodule
